uart_rx: RTL

UART receiver that consumes the 16x-oversample tick BCLK from the baud rate generator and deserialises the asynchronous line rx into parallel bytes. It sits directly downstream of the baud generator, in the same clk domain. It synchronises rx, validates the start bit at mid-bit, samples each data bit at its centre, and checks the stop bit. It presents each received byte with a one-cycle done pulse or a framing-error pulse.

---
 rtl/uart_rx.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver: start-bit validation at mid-bit, centre sampling of
// each data bit, stop-bit check, and break suppression after a framing error.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 BCLK,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t                 state_q;
    logic [TW-1:0]          tick_q;
    logic [BW-1:0]          bit_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [DATA_BITS-1:0]   data_q;
    logic                   rx_meta_q;
    logic                   rx_s_q;
    logic                   rx_done_q;
    logic                   frame_err_q;
    logic                   rx_busy_q;

    // Two-flop synchroniser, idles high so reset does not look like a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            tick_q      <= '0;
            bit_q       <= '0;
            data_q      <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rx_busy_q   <= 1'b0;
        end else begin
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_q   <= START;
                        tick_q    <= '0;
                        rx_busy_q <= 1'b1;
                    end
                end
                START: begin
                    if (BCLK) begin
                        if (tick_q == TICK_MID) begin
                            if (!rx_s_q) begin
                                state_q <= DATA;
                                tick_q  <= '0;
                                bit_q   <= '0;
                            end else begin
                                state_q   <= IDLE;
                                rx_busy_q <= 1'b0;
                            end
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (BCLK) begin
                        if (tick_q == TICK_LAST) begin
                            shift_q <= {rx_s_q, shift_q[DATA_BITS-1:1]};
                            tick_q  <= '0;
                            bit_q   <= bit_q + 1'b1;
                            if (bit_q == BIT_LAST) begin
                                state_q <= STOP;
                            end
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                end
                STOP: begin
                    // Leaving at mid-stop-bit lets a zero-gap next start edge be caught.
                    if (BCLK) begin
                        if (tick_q == TICK_LAST) begin
                            tick_q <= '0;
                            if (rx_s_q) begin
                                data_q    <= shift_q;
                                rx_done_q <= 1'b1;
                                state_q   <= IDLE;
                                rx_busy_q <= 1'b0;
                            end else begin
                                frame_err_q <= 1'b1;
                                state_q     <= WAIT_HIGH;
                            end
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s_q) begin
                        state_q   <= IDLE;
                        rx_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    rx_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign data      = data_q;
    assign rx_done   = rx_done_q;
    assign frame_err = frame_err_q;
    assign rx_busy   = rx_busy_q;

endmodule
